slave_port_arbiter: RTL and testbench
=====================================

// Module: slave_port_arbiter
// PURPOSE
//  Per-slave-port arbiter for the master/slave crossbar: one instance per slave. Picks one of
//  NUM_MASTERS requesters addressing this slave (addr MSB == SLAVE_ID), round-robin, holds the
//  grant until the slave acks, and forwards addr/cmd/wdata. Records each accepted read in an
//  in-order ID FIFO so slave read responses are returned to the correct master.
// PARAMETERS
//  NUM_MASTERS      2   requesting masters (>=2)
//  SLAVE_ID         0   value of addr[ADDR_W-1] that selects this slave (0 or 1)
//  ADDR_W           32  master address width; slave sees ADDR_W-1 bits
//  DATA_W           32  wdata/rdata width
//  MAX_OUTSTANDING  4   read responses pending at once; power of 2, >=2
// PORTS
//  clk       in   1                 single clock, rising edge
//  rst_n     in   1                 asynchronous, active-low reset
//  m_req     in   NUM_MASTERS       per-master request; held with addr/cmd/wdata until m_ack
//  m_cmd     in   NUM_MASTERS       1=write, 0=read
//  m_addr    in   NUM_MASTERS*ADDR_W   packed, master i at [i*ADDR_W +: ADDR_W]
//  m_wdata   in   NUM_MASTERS*DATA_W   packed likewise
//  m_ack     out  NUM_MASTERS       one-hot, single-cycle acceptance
//  m_resp    out  NUM_MASTERS       one-hot, single-cycle read-data valid
//  m_rdata   out  DATA_W            s_rdata broadcast; qualified by m_resp
//  s_req     out  1                 request to slave
//  s_cmd     out  1                 granted master's cmd
//  s_addr    out  ADDR_W-1          granted master's addr[ADDR_W-2:0]
//  s_wdata   out  DATA_W            granted master's wdata
//  s_ack     in   1                 slave accepts request this cycle (valid only while s_req)
//  s_resp    in   1                 slave read data valid; reads return in acceptance order
//  s_rdata   in   DATA_W            read data
//  err       out  1                 sticky: s_resp with no read outstanding
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, rr_ptr=0, FIFO empty, err=0; s_req, m_ack, m_resp all 0.
//  - Eligible[i] = m_req[i] & (m_addr[i][ADDR_W-1]==SLAVE_ID) & (m_cmd[i] | !fifo_full).
//  - IDLE: if any eligible, register gnt = first eligible at/after rr_ptr (wrapping); -> BUSY.
//  - BUSY: s_req = m_req[gnt] (combinational); s_cmd/s_addr/s_wdata muxed from gnt.
//    m_ack[gnt] = s_ack & s_req. On ack: if read, push gnt into FIFO; rr_ptr = gnt+1 mod N;
//    -> IDLE. No new grant issued in the ack cycle.
//  - Latency: eligible req at cycle T -> s_req high T+1; ack at T+k -> next grant earliest
//    T+k+1, its s_req T+k+2. Single-cycle ack: one transaction per 2 cycles.
//  - Master drops m_req while BUSY (violation): s_req falls, -> IDLE, no push, rr_ptr unchanged.
//  - s_ack outside BUSY or while s_req=0: ignored.
//  - Response: m_resp[fifo_head] = s_resp & !fifo_empty, pop same cycle. Push and pop in the
//    same cycle are both honoured (count unchanged, correct even when full or empty-after-push
//    is not allowed: pop reads head before push). s_resp with FIFO empty: dropped, err<=1.
//  - FIFO full: reads not eligible (writes still granted); pop in a cycle frees a slot next cycle.
//  - Pointers wrap mod MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.
//  - Reset mid-transaction: everything returns to reset values immediately; outstanding read
//    IDs are discarded, later s_resp sets err.
// STRUCTURE
//  - Package crossbar_pkg: CMD_READ=1'b0, CMD_WRITE=1'b1, state enum {IDLE,BUSY},
//    master-index width function idx_w(n)=max(1,clog2(n)).
//  - Sub-module resp_order_fifo (width idx_w(NUM_MASTERS), depth MAX_OUTSTANDING; push, pop,
//    head, full, empty). Arbiter FSM, round-robin pick and muxes stay in top.
// TESTING
//  1. Reset: rst_n=0 mid-BUSY with m_req=2'b11 -> s_req, m_ack, m_resp=0 async; err=0.
//  2. Contention: both write to SLAVE_ID=0 (addr 0x0000_0010 / 0x0000_0020), ack 1 cycle after
//     each s_req -> order M0,M1,M0,M1; s_addr=31'h10 then 31'h20; m_ack one-hot, 1 cycle each.
//  3. Decode: M1 addr 0x8000_0004 on SLAVE_ID=0 instance -> never granted, s_req stays 0.
//  4. Read ordering: M0 read, M1 read, both acked; s_resp rdata 0xAAAA_0000 then 0x5555_0000
//     -> m_resp[0] with 0xAAAA_0000 first, then m_resp[1] with 0x5555_0000.
//  5. FIFO full: 4 unanswered reads, M0 read pending + M1 write -> M1 write granted, M0 held;
//     one s_resp -> M0 granted next IDLE.
//  6. Error/abort: s_resp with FIFO empty -> err=1 sticky; M0 drops m_req in BUSY -> s_req=0,
//     no m_ack, FIFO count unchanged.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared definitions for the master/slave crossbar: command encoding,
// arbiter state type and the master-index width helper.
package crossbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  // Width of a master index; a single master still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// In-order FIFO of master indices for accepted reads; head names the master
// that owns the next slave read response.
module resp_order_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             count;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written, so full+pop may push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave round-robin arbiter: grants one master at a time, holds until the
// slave acks, and routes in-order read responses back via resp_order_fifo.
module slave_port_arbiter
  import crossbar_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int SLAVE_ID        = 0,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_resp,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [ADDR_W-2:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic                          s_resp,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          err
);

  localparam int   IW        = idx_w(NUM_MASTERS);
  localparam logic SLAVE_BIT = 1'(SLAVE_ID);

  arb_state_e state, state_nxt;
  logic [IW-1:0] gnt, gnt_nxt, rr_ptr, rr_ptr_nxt, pick, head;
  logic          any_elig, ack_fire, push, full, empty;

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_MASTERS-1:0]             eligible;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    assign addr_v[i]   = m_addr[i*ADDR_W +: ADDR_W];
    assign wdata_v[i]  = m_wdata[i*DATA_W +: DATA_W];
    // Reads need a free response slot; writes never wait on the FIFO.
    assign eligible[i] = m_req[i] & (addr_v[i][ADDR_W-1] == SLAVE_BIT) &
                         ((m_cmd[i] == CMD_WRITE) | ~full);
  end

  // First eligible master at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    any_elig = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_MASTERS;
      if (!any_elig && eligible[idx]) begin
        pick     = IW'(idx);
        any_elig = 1'b1;
      end
    end
  end

  assign s_req    = (state == BUSY) & m_req[gnt];
  assign s_cmd    = m_cmd[gnt];
  assign s_addr   = addr_v[gnt][ADDR_W-2:0];
  assign s_wdata  = wdata_v[gnt];
  assign ack_fire = s_req & s_ack;
  assign push     = ack_fire & (m_cmd[gnt] == CMD_READ);
  assign m_rdata  = s_rdata;

  always_comb begin
    m_ack = '0;
    if (ack_fire) m_ack[gnt] = 1'b1;
  end

  always_comb begin
    m_resp = '0;
    if (s_resp && !empty) m_resp[head] = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: if (any_elig) begin
        gnt_nxt   = pick;
        state_nxt = BUSY;
      end
      BUSY: begin
        // A master withdrawing mid-grant abandons the slot without moving rr_ptr.
        if (!m_req[gnt]) begin
          state_nxt = IDLE;
        end else if (s_ack) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (gnt == IW'(NUM_MASTERS - 1)) ? '0 : gnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (s_resp && empty) err <= 1'b1;
    end
  end

  resp_order_fifo #(
    .W     (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (gnt),
    .pop       (s_resp),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter (2 masters, SLAVE_ID=0): vector table, directed
// corner sequences, then random traffic against a transaction-level model.
module tb_slave_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  m_req, m_cmd, m_ack, m_resp;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata;
  logic          s_req, s_cmd, s_ack, s_resp, err;
  logic [AW-2:0] s_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slave_port_arbiter #(
    .NUM_MASTERS(N), .SLAVE_ID(0), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic cmd,
                       input logic [31:0] a, input logic [31:0] wd);
    m_req[i] = req;
    m_cmd[i] = cmd;
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*DW +: DW] = wd;
  endtask

  task automatic idle_inputs();
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Wait (bounded) for s_req, then ack for one cycle; master i drops afterwards.
  task automatic run_txn(input int i, input string nm);
    int t = 0;
    #2;
    while (!s_req && t < 10) begin cyc(); #2; t++; end
    chk({nm, " s_req"}, 64'(s_req), 64'(1));
    s_ack = 1'b1;
    #1;
    chk({nm, " m_ack"}, 64'(m_ack), 64'(1 << i));
    cyc();
    s_ack = 1'b0;
    m_req[i] = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  req, cmd;
    logic        ack, resp;
    logic [31:0] rdata;
    logic        e_sreq;
    logic [1:0]  e_ack, e_resp;
    logic [30:0] e_addr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] req, input logic [1:0] cmd, input logic ack,
                     input logic resp, input logic [31:0] rdata, input logic e_sreq,
                     input logic [1:0] e_ack, input logic [1:0] e_resp, input logic [30:0] e_addr);
    vec_t v;
    v.req = req; v.cmd = cmd; v.ack = ack; v.resp = resp; v.rdata = rdata;
    v.e_sreq = e_sreq; v.e_ack = e_ack; v.e_resp = e_resp; v.e_addr = e_addr;
    tbl.push_back(v);
  endtask

  // random-phase model state
  bit          pend[N];
  logic        pcmd[N];
  logic [31:0] paddr[N], pwd[N];
  int          age[N];
  int          g, rr;
  int          q[$];
  bit          merr;

  initial begin
    idle_inputs();
    do_reset();

    // Contention on writes (M0 0x10, M1 0x20), then two reads and their responses.
    add(2'b11, 2'b11, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);
    add(2'b11, 2'b11, 0, 0, 0,            1, 2'b00, 2'b00, 31'h10);
    add(2'b11, 2'b11, 1, 0, 0,            1, 2'b01, 2'b00, 31'h10);
    add(2'b11, 2'b11, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);
    add(2'b11, 2'b11, 0, 0, 0,            1, 2'b00, 2'b00, 31'h20);
    add(2'b11, 2'b11, 1, 0, 0,            1, 2'b10, 2'b00, 31'h20);
    add(2'b11, 2'b11, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);
    add(2'b11, 2'b11, 1, 0, 0,            1, 2'b01, 2'b00, 31'h10);
    add(2'b11, 2'b11, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);
    add(2'b11, 2'b11, 1, 0, 0,            1, 2'b10, 2'b00, 31'h20);
    add(2'b11, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);
    add(2'b11, 2'b00, 1, 0, 0,            1, 2'b01, 2'b00, 31'h10);
    add(2'b11, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);
    add(2'b11, 2'b00, 1, 0, 0,            1, 2'b10, 2'b00, 31'h20);
    add(2'b00, 2'b00, 0, 1, 32'hAAAA_0000, 0, 2'b00, 2'b01, 31'h00);
    add(2'b00, 2'b00, 0, 1, 32'h5555_0000, 0, 2'b00, 2'b10, 31'h00);
    add(2'b00, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 31'h00);

    set_m(0, 0, 0, 32'h0000_0010, 32'h1111_1111);
    set_m(1, 0, 0, 32'h0000_0020, 32'h2222_2222);
    foreach (tbl[r]) begin
      m_req = tbl[r].req; m_cmd = tbl[r].cmd;
      s_ack = tbl[r].ack; s_resp = tbl[r].resp; s_rdata = tbl[r].rdata;
      #2;
      chk($sformatf("vec%0d s_req", r), 64'(s_req), 64'(tbl[r].e_sreq));
      chk($sformatf("vec%0d m_ack", r), 64'(m_ack), 64'(tbl[r].e_ack));
      chk($sformatf("vec%0d m_resp", r), 64'(m_resp), 64'(tbl[r].e_resp));
      chk($sformatf("vec%0d err", r), 64'(err), 64'(0));
      if (tbl[r].e_sreq) chk($sformatf("vec%0d s_addr", r), 64'(s_addr), 64'(tbl[r].e_addr));
      if (tbl[r].e_resp != 2'b00) chk($sformatf("vec%0d m_rdata", r), 64'(m_rdata), 64'(tbl[r].rdata));
      cyc();
    end

    // Decode: M1 targets the other slave and must never be granted.
    do_reset();
    set_m(1, 1, 1, 32'h8000_0004, 32'hDEAD_BEEF);
    s_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("decode s_req", 64'(s_req), 64'(0));
      chk("decode m_ack", 64'(m_ack), 64'(0));
      cyc();
    end

    // FIFO full: 4 unanswered reads (last from M1 so rr points at M0).
    do_reset();
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin set_m(1, 1, 0, 32'h0000_0020, 0); run_txn(1, "fill"); end
      else begin set_m(0, 1, 0, 32'h0000_0010, 0); run_txn(0, "fill"); end
    end
    set_m(0, 1, 0, 32'h0000_0010, 0);
    set_m(1, 1, 1, 32'h0000_0020, 32'h2222_2222);
    #2; chk("full idle s_req", 64'(s_req), 64'(0));
    cyc();
    #2;
    chk("full wr s_req", 64'(s_req), 64'(1));
    chk("full wr s_addr", 64'(s_addr), 64'h20);
    chk("full wr s_cmd", 64'(s_cmd), 64'(1));
    s_ack = 1'b1; #1;
    chk("full wr m_ack", 64'(m_ack), 64'b10);
    cyc(); s_ack = 1'b0; m_req[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2; chk("full rd held", 64'(s_req), 64'(0));
      cyc();
    end
    s_resp = 1'b1; s_rdata = 32'h1234_5678;
    #2;
    chk("full pop m_resp", 64'(m_resp), 64'b01);
    chk("full pop s_req", 64'(s_req), 64'(0));
    cyc(); s_resp = 1'b0;
    #2; chk("full regrant idle", 64'(s_req), 64'(0));
    cyc();
    #2;
    chk("full rd s_req", 64'(s_req), 64'(1));
    chk("full rd s_addr", 64'(s_addr), 64'h10);
    s_ack = 1'b1; #1;
    chk("full rd m_ack", 64'(m_ack), 64'b01);
    cyc(); s_ack = 1'b0; m_req = '0;

    // Error and abort.
    do_reset();
    s_resp = 1'b1;
    #2;
    chk("err resp dropped", 64'(m_resp), 64'(0));
    chk("err before edge", 64'(err), 64'(0));
    cyc(); s_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2; chk("err sticky", 64'(err), 64'(1));
      cyc();
    end
    set_m(0, 1, 0, 32'h0000_0010, 0);
    cyc();
    #2; chk("abort s_req up", 64'(s_req), 64'(1));
    m_req[0] = 1'b0; s_ack = 1'b1;
    #1;
    chk("abort s_req drop", 64'(s_req), 64'(0));
    chk("abort m_ack", 64'(m_ack), 64'(0));
    cyc(); s_ack = 1'b0;
    #2; chk("abort idle", 64'(s_req), 64'(0));
    s_resp = 1'b1; #1;
    chk("abort no push", 64'(m_resp), 64'(0));
    cyc(); s_resp = 1'b0;

    // Async reset in the middle of a grant.
    set_m(0, 1, 1, 32'h0000_0010, 0);
    set_m(1, 1, 1, 32'h0000_0020, 0);
    cyc();
    #2; chk("rst busy s_req", 64'(s_req), 64'(1));
    s_ack = 1'b1; s_resp = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst s_req", 64'(s_req), 64'(0));
    chk("rst m_ack", 64'(m_ack), 64'(0));
    chk("rst m_resp", 64'(m_resp), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    cyc();
    #2; chk("rst held s_req", 64'(s_req), 64'(0));
    idle_inputs();
    rst_n = 1'b1;
    cyc();

    // Random traffic against a transaction-level model.
    do_reset();
    g = -1; rr = 0; q.delete(); merr = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pcmd[i] = 0; paddr[i] = 0; pwd[i] = 0; age[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      logic       e_sreq, full;
      logic [1:0] e_ack, e_resp;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i]  = 1;
          pcmd[i]  = 1'($urandom_range(1));
          paddr[i] = {($urandom_range(7) == 0), 31'($urandom)};
          pwd[i]   = $urandom;
          age[i]   = 0;
        end else if (pend[i] && paddr[i][31] && age[i] >= 3) begin
          pend[i] = 0;
        end
        if (pend[i]) age[i]++;
        set_m(i, pend[i], pcmd[i], paddr[i], pwd[i]);
      end
      s_ack   = 1'($urandom_range(1));
      s_resp  = ($urandom_range(3) == 0);
      s_rdata = $urandom;
      #2;
      e_sreq = (g >= 0) && pend[g];
      e_ack  = (e_sreq && s_ack) ? 2'(1 << g) : 2'b00;
      e_resp = (s_resp && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
      chk("rnd s_req", 64'(s_req), 64'(e_sreq));
      chk("rnd m_ack", 64'(m_ack), 64'(e_ack));
      chk("rnd m_resp", 64'(m_resp), 64'(e_resp));
      chk("rnd err", 64'(err), 64'(merr));
      if (e_sreq) begin
        chk("rnd s_addr", 64'(s_addr), 64'(paddr[g][30:0]));
        chk("rnd s_cmd", 64'(s_cmd), 64'(pcmd[g]));
        chk("rnd s_wdata", 64'(s_wdata), 64'(pwd[g]));
      end
      if (e_resp != 2'b00) chk("rnd m_rdata", 64'(m_rdata), 64'(s_rdata));

      full = (q.size() == 4);
      if (s_resp) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (g >= 0) begin
        if (e_sreq && s_ack) begin
          if (pcmd[g] == 1'b0) q.push_back(g);
          pend[g] = 0;
          rr = (g + 1) % N;
          g = -1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (rr + k) % N;
          if (g < 0 && pend[idx] && paddr[idx][31] == 1'b0 && (pcmd[idx] || !full)) g = idx;
        end
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
